// File: rtl/data_mem_responder.sv
// Data-memory responder for the multicycle core: a word-organised RAM split
// into four byte lanes, with lane steering for stores, sign/zero extension for
// loads, a one-cycle read response, an optional post-reset clear sequencer and
// sticky capture of the first faulting address.
module data_mem_responder #(
  parameter int DEPTH        = 256,
  parameter bit CLEAR_ON_RST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        mem_wen,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        err_clr,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic        init_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          clearing;

  logic          accept, out_of_range, misaligned, bad, rd_req, ok_rd, ok_wr;
  logic [3:0]    byte_en;
  logic [31:0]   store_word;
  logic [AW-1:0] word_idx, w_idx;
  logic [3:0]    lane_we;
  logic [31:0]   lane_wdata;
  logic [31:0]   raw_word;

  logic          rvalid_q, rsp_zero_q, rsp_uns_q;
  logic [1:0]    rsp_size_q, rsp_off_q;
  logic          fault_q;
  logic [31:0]   fault_addr_q;

  // State register and clear index; reset restarts any clear from word 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state logic: sweep every word once, then start accepting requests.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clearing  = 1'b0;
    init_done = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clearing  = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN:   init_done = 1'b1;
      default:  state_d = ST_RUN;
    endcase
  end

  // Request decode: fault detection, lane enables and right-justified data replication.
  always_comb begin
    accept       = mem_en & init_done;
    out_of_range = |addr[31:AW+2];
    misaligned   = 1'b0;
    byte_en      = 4'b0000;
    store_word   = wdata;
    case (mem_size)
      2'b00: begin
        byte_en    = 4'b0001 << addr[1:0];
        store_word = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        byte_en    = addr[1] ? 4'b1100 : 4'b0011;
        store_word = {2{wdata[15:0]}};
      end
      2'b10: begin
        misaligned = |addr[1:0];
        byte_en    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
    bad      = misaligned | out_of_range;
    rd_req   = accept & ~mem_wen;
    ok_rd    = rd_req & ~bad;
    ok_wr    = accept & mem_wen & ~bad;
    word_idx = addr[AW+1:2];
  end

  // The clear sequencer owns the write port while it runs.
  always_comb begin
    w_idx      = clearing ? clr_idx_q : word_idx;
    lane_wdata = clearing ? 32'h0 : store_word;
    lane_we    = clearing ? 4'b1111 : (byte_en & {4{ok_wr}});
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram [DEPTH];
      logic [7:0] rd_q;
      // One byte lane: independent write enable, registered read.
      always_ff @(posedge clk) begin
        if (lane_we[gi]) ram[w_idx] <= lane_wdata[8*gi +: 8];
        if (ok_rd)       rd_q       <= ram[word_idx];
      end
      assign raw_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  // Response bookkeeping: remember how to extend the word that the lanes just captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q   <= 1'b0;
      rsp_zero_q <= 1'b1;
      rsp_uns_q  <= 1'b0;
      rsp_size_q <= 2'b00;
      rsp_off_q  <= 2'b00;
    end else begin
      rvalid_q <= rd_req;
      if (rd_req) begin
        rsp_zero_q <= bad;
        rsp_uns_q  <= mem_unsigned;
        rsp_size_q <= mem_size;
        rsp_off_q  <= addr[1:0];
      end
    end
  end

  // Sticky fault: first address is kept; a new fault outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else if (accept && bad) begin
      if (!fault_q || err_clr) begin
        fault_q      <= 1'b1;
        fault_addr_q <= addr;
      end
    end else if (err_clr) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end
  end

  // Load extension from the captured word; faulted or reset responses read as zero.
  always_comb begin
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    sel_b = raw_word[7:0];
    case (rsp_off_q)
      2'd1:    sel_b = raw_word[15:8];
      2'd2:    sel_b = raw_word[23:16];
      2'd3:    sel_b = raw_word[31:24];
      default: sel_b = raw_word[7:0];
    endcase
    sel_h = rsp_off_q[1] ? raw_word[31:16] : raw_word[15:0];
    rdata = 32'h0;
    if (!rsp_zero_q) begin
      case (rsp_size_q)
        2'b00:   rdata = {{24{~rsp_uns_q & sel_b[7]}}, sel_b};
        2'b01:   rdata = {{16{~rsp_uns_q & sel_h[15]}}, sel_h};
        2'b10:   rdata = raw_word;
        default: rdata = 32'h0;
      endcase
    end
  end

  assign rvalid     = rvalid_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a 256-word responder and a 16-word clear-on-reset responder
// share one request bus but have separate resets.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n, c_rst_n;
  logic        mem_en, mem_wen, mem_unsigned, err_clr;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;

  logic [31:0] rdata, fault_addr, c_rdata, c_fault_addr;
  logic        rvalid, fault, init_done, c_rvalid, c_fault, c_init_done;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.DEPTH(256), .CLEAR_ON_RST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .mem_wen(mem_wen),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr),
    .wdata(wdata), .err_clr(err_clr), .rdata(rdata), .rvalid(rvalid),
    .fault(fault), .fault_addr(fault_addr), .init_done(init_done)
  );

  data_mem_responder #(.DEPTH(16), .CLEAR_ON_RST(1'b1)) dut_c (
    .clk(clk), .rst_n(c_rst_n), .mem_en(mem_en), .mem_wen(mem_wen),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr),
    .wdata(wdata), .err_clr(err_clr), .rdata(c_rdata), .rvalid(c_rvalid),
    .fault(c_fault), .fault_addr(c_fault_addr), .init_done(c_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    $display("check %-18s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One request cycle; outputs are sampled 1 time unit after the accepting edge.
  task automatic req(input logic wen, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] d);
    mem_en       = 1'b1;
    mem_wen      = wen;
    mem_size     = sz;
    mem_unsigned = uns;
    addr         = a;
    wdata        = d;
    tick();
    mem_en  = 1'b0;
    mem_wen = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; c_rst_n = 1'b0;
    mem_en = 1'b0; mem_wen = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    chk("rst_init_done", {31'h0, init_done}, 32'h1);
    chk("rst_c_init_done", {31'h0, c_init_done}, 32'h0);
    rst_n = 1'b1; c_rst_n = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    chk("c_init_after_16", {31'h0, c_init_done}, 32'h1);

    // Word store/load, then hold check.
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_no_rvalid", {31'h0, rvalid}, 32'h0);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_rvalid", {31'h0, rvalid}, 32'h1);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    tick();
    chk("idle_rvalid", {31'h0, rvalid}, 32'h0);
    chk("idle_rdata_hold", rdata, 32'hDEADBEEF);

    // Byte/half extension.
    req(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01);
    req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
    chk("lb_23", rdata, 32'hFFFFFF80);
    req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
    chk("lbu_23", rdata, 32'h00000080);
    req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    chk("lh_22", rdata, 32'hFFFF80FF);
    req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    chk("lhu_20", rdata, 32'h00007F01);
    req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    chk("lb_20", rdata, 32'h00000001);

    // Partial stores, back-to-back with the loads.
    req(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344);
    req(1'b1, 2'b00, 1'b0, 32'h31, 32'h123456AB);
    req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    chk("sb_31_lw", rdata, 32'h1122AB44);
    req(1'b1, 2'b01, 1'b0, 32'h32, 32'h9876CDEF);
    req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    chk("sh_32_lw", rdata, 32'hCDEFAB44);

    // Faults.
    req(1'b1, 2'b10, 1'b0, 32'h0, 32'h12345678);
    req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    chk("lw_mis_rvalid", {31'h0, rvalid}, 32'h1);
    chk("lw_mis_rdata", rdata, 32'h0);
    chk("lw_mis_fault", {31'h0, fault}, 32'h1);
    chk("lw_mis_faddr", fault_addr, 32'h6);
    req(1'b1, 2'b10, 1'b0, 32'h2000, 32'hFFFFFFFF);
    chk("oor_faddr_keep", fault_addr, 32'h6);
    req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("oor_ram_kept", rdata, 32'h12345678);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_fault", {31'h0, fault}, 32'h0);
    chk("clr_faddr", fault_addr, 32'h0);
    req(1'b0, 2'b01, 1'b1, 32'h21, 32'h0);
    chk("lh_odd_faddr", fault_addr, 32'h21);
    chk("lh_odd_rdata", rdata, 32'h0);
    err_clr = 1'b1;
    req(1'b0, 2'b11, 1'b0, 32'h44, 32'h0);
    err_clr = 1'b0;
    chk("clr_vs_new_fault", {31'h0, fault}, 32'h1);
    chk("clr_vs_new_faddr", fault_addr, 32'h44);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Reset mid-read.
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("pre_rst_rdata", rdata, 32'hDEADBEEF);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);

    // Clear sequencer on the 16-word instance, which saw the same stores.
    req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    chk("c_dirty", c_rdata, 32'hCDEFAB44);
    c_rst_n = 1'b0; tick(); tick(); c_rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) begin
        req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        chk("c_drop_rvalid", {31'h0, c_rvalid}, 32'h0);
        chk("c_drop_fault", {31'h0, c_fault}, 32'h0);
      end else begin
        tick();
      end
      if (i == 15) chk("c_busy_15", {31'h0, c_init_done}, 32'h0);
    end
    chk("c_done_16", {31'h0, c_init_done}, 32'h1);
    req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    chk("c_lw30_rvalid", {31'h0, c_rvalid}, 32'h1);
    chk("c_lw30_zero", c_rdata, 32'h0);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("c_lw10_zero", c_rdata, 32'h0);
    req(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    chk("c_lw3c_zero", c_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
